// File: rtl/fifo18_rr_arb.sv
// Round-robin arbiter merging two 18-bit FWFT source FIFOs into one sink FIFO.
// Frames are forwarded atomically; a stalled frame is closed with a 00000 word after Timeout empty cycles.
module fifo18_rr_arb #(
    parameter logic [7:0] Timeout = 8'd64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [17:0] dout0,
    input  logic [17:0] dout1,
    input  logic        empty0,
    input  logic        empty1,
    output logic        rd_en0,
    output logic        rd_en1,
    output logic [17:0] din,
    output logic        wr_en,
    input  logic        full,
    output logic [7:0]  frame_count0,
    output logic [7:0]  frame_count1,
    output logic [7:0]  drop_count,
    output logic [7:0]  abort_count,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state;
    logic        last_port;
    logic [7:0]  idle_cnt;

    logic        elig0, elig1, disc0, disc1;
    logic        timeout_hit;
    logic        gnt_port;
    logic [17:0] gnt_dout;
    logic        gnt_rd;

    always_comb begin
        elig0       = !empty0 && dout0[17];
        elig1       = !empty1 && dout1[17];
        disc0       = !empty0 && !dout0[17];
        disc1       = !empty1 && !dout1[17];
        timeout_hit = (idle_cnt >= Timeout);
        gnt_port    = (state == GNT1);
        gnt_dout    = gnt_port ? dout1 : dout0;
        rd_en0      = 1'b0;
        rd_en1      = 1'b0;
        if (!sys_rst && !full) begin
            case (state)
                IDLE: begin
                    // Discard pops only when nobody is eligible; ties go away from last_port.
                    if (!elig0 && !elig1) begin
                        if (disc0 && disc1) begin
                            rd_en0 = last_port;
                            rd_en1 = !last_port;
                        end else begin
                            rd_en0 = disc0;
                            rd_en1 = disc1;
                        end
                    end
                end
                GNT0:    rd_en0 = !empty0 && !timeout_hit;
                GNT1:    rd_en1 = !empty1 && !timeout_hit;
                default: ;
            endcase
        end
        gnt_rd = rd_en0 || rd_en1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            last_port    <= 1'b1;
            idle_cnt     <= '0;
            din          <= '0;
            wr_en        <= 1'b0;
            grant        <= '0;
            frame_count0 <= '0;
            frame_count1 <= '0;
            drop_count   <= '0;
            abort_count  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (!full) begin
                case (state)
                    IDLE: begin
                        if (elig0 && (!elig1 || last_port)) begin
                            state    <= GNT0;
                            grant    <= 2'b01;
                            idle_cnt <= '0;
                        end else if (elig1) begin
                            state    <= GNT1;
                            grant    <= 2'b10;
                            idle_cnt <= '0;
                        end else if (gnt_rd) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                    GNT0, GNT1: begin
                        if (timeout_hit) begin
                            din         <= '0;
                            wr_en       <= 1'b1;
                            abort_count <= abort_count + 8'd1;
                            last_port   <= gnt_port;
                            state       <= IDLE;
                            grant       <= '0;
                        end else if (gnt_rd) begin
                            din      <= gnt_dout;
                            wr_en    <= 1'b1;
                            idle_cnt <= '0;
                            if (gnt_dout[17:16] == 2'b00) begin
                                if (gnt_port)
                                    frame_count1 <= frame_count1 + 8'd1;
                                else
                                    frame_count0 <= frame_count0 + 8'd1;
                                last_port <= gnt_port;
                                state     <= IDLE;
                                grant     <= '0;
                            end
                        end else begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        grant <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo18_rr_arb.sv
// Directed bench for fifo18_rr_arb: FWFT source models, sink capture, immediate-assertion checks.
module tb_fifo18_rr_arb;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [17:0] dout0 = '0, dout1 = '0;
    logic        empty0 = 1'b1, empty1 = 1'b1;
    logic        rd_en0, rd_en1;
    logic [17:0] din;
    logic        wr_en;
    logic        full = 1'b0;
    logic [7:0]  frame_count0, frame_count1, drop_count, abort_count;
    logic [1:0]  grant;

    fifo18_rr_arb #(.Timeout(8'd4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .dout0        (dout0),
        .dout1        (dout1),
        .empty0       (empty0),
        .empty1       (empty1),
        .rd_en0       (rd_en0),
        .rd_en1       (rd_en1),
        .din          (din),
        .wr_en        (wr_en),
        .full         (full),
        .frame_count0 (frame_count0),
        .frame_count1 (frame_count1),
        .drop_count   (drop_count),
        .abort_count  (abort_count),
        .grant        (grant)
    );

    always #5 sys_clk = ~sys_clk;

    logic [17:0] q0[$], q1[$], wq[$];
    int          wcyc[$];
    int          cyc_n = 0;
    int          fall0 = -100;
    int          vectors = 0;
    int          miscompares = 0;
    logic        p0, p1;

    task automatic refresh();
        if (empty0 && q0.size() > 0) fall0 = cyc_n;
        empty0 = (q0.size() == 0);
        dout0  = empty0 ? 18'h0 : q0[0];
        empty1 = (q1.size() == 0);
        dout1  = empty1 ? 18'h0 : q1[0];
    endtask

    // Source FIFOs and sink capture; rd_en is sampled just before the rising edge.
    always begin
        @(negedge sys_clk);
        #1 refresh();
        #3;
        p0 = rd_en0;
        p1 = rd_en1;
        @(posedge sys_clk);
        cyc_n++;
        #1;
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        if (wr_en) begin
            wq.push_back(din);
            wcyc.push_back(cyc_n);
        end
        refresh();
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wq_at(input int i);
        return (i < wq.size()) ? {14'h0, wq[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic int wcyc_at(input int i);
        return (i < wcyc.size()) ? wcyc[i] : -1000;
    endfunction

    task automatic do_reset();
        sys_rst = 1'b1;
        q0.delete();
        q1.delete();
        cyc(2);
        wq.delete();
        wcyc.delete();
        sys_rst = 1'b0;
        cyc(1);
    endtask

    logic [17:0] exp6[6];
    logic [17:0] exp5[5];

    initial begin
        #1 sys_rst = 1'b1;
        cyc(2);
        check("rst_grant", grant, 2'b00);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_din", din, 18'h0);
        check("rst_counts", {frame_count0, frame_count1, drop_count, abort_count}, 32'h0);
        q0.push_back(18'h00000);
        cyc(2);
        check("rst_rd_en0", rd_en0, 1'b0);
        check("rst_drop_hold", drop_count, 8'h0);
        q0.delete();
        cyc(1);
        sys_rst = 1'b0;
        cyc(1);

        // single frame on port 0
        q0.push_back(18'h3FFAA); q0.push_back(18'h3FFBB);
        q0.push_back(18'h2CC00); q0.push_back(18'h00000);
        cyc(2);
        check("s1_grant", grant, 2'b01);
        cyc(8);
        check("s1_nwords", wq.size(), 4);
        check("s1_w0", wq_at(0), 18'h3FFAA);
        check("s1_w1", wq_at(1), 18'h3FFBB);
        check("s1_w2", wq_at(2), 18'h2CC00);
        check("s1_w3", wq_at(3), 18'h00000);
        check("s1_latency", wcyc_at(0) - fall0, 2);
        check("s1_consec", wcyc_at(3) - wcyc_at(0), 3);
        check("s1_fc0", frame_count0, 8'd1);
        check("s1_grant_end", grant, 2'b00);

        // simultaneous frames after reset: port 0 first, twice
        do_reset();
        q0.push_back(18'h3F001); q0.push_back(18'h3F002); q0.push_back(18'h00003);
        q1.push_back(18'h3F011); q1.push_back(18'h3F012); q1.push_back(18'h00013);
        cyc(14);
        exp6 = '{18'h3F001, 18'h3F002, 18'h00003, 18'h3F011, 18'h3F012, 18'h00013};
        check("s2a_nwords", wq.size(), 6);
        for (int i = 0; i < 6; i++) check("s2a_word", wq_at(i), exp6[i]);
        check("s2a_fc", {frame_count0, frame_count1}, 16'h0101);
        wq.delete();
        q0.push_back(18'h3F021); q0.push_back(18'h3F022); q0.push_back(18'h00023);
        q1.push_back(18'h3F031); q1.push_back(18'h3F032); q1.push_back(18'h00033);
        cyc(14);
        exp6 = '{18'h3F021, 18'h3F022, 18'h00023, 18'h3F031, 18'h3F032, 18'h00033};
        check("s2b_nwords", wq.size(), 6);
        for (int i = 0; i < 6; i++) check("s2b_word", wq_at(i), exp6[i]);
        check("s2b_fc", {frame_count0, frame_count1}, 16'h0202);
        wq.delete();

        // stray gap words while idle
        q0.push_back(18'h00000); q0.push_back(18'h00000); q0.push_back(18'h00000);
        cyc(7);
        check("s3_drop", drop_count, 8'd3);
        check("s3_nowrite", wq.size(), 0);
        q0.push_back(18'h00000);
        q1.push_back(18'h3F0AA); q1.push_back(18'h00000);
        cyc(8);
        check("s3_elig_nwords", wq.size(), 2);
        check("s3_elig_w0", wq_at(0), 18'h3F0AA);
        check("s3_elig_w1", wq_at(1), 18'h00000);
        check("s3_elig_drop", drop_count, 8'd4);
        check("s3_elig_fc1", frame_count1, 8'd3);
        wq.delete();
        wcyc.delete();

        // stalled frame aborted after Timeout empty cycles
        q0.push_back(18'h3F101); q0.push_back(18'h3F102);
        cyc(14);
        check("s4_nwords", wq.size(), 3);
        check("s4_w2", wq_at(2), 18'h00000);
        check("s4_gap", wcyc_at(2) - wcyc_at(1), 5);
        check("s4_abort", abort_count, 8'd1);
        check("s4_grant", grant, 2'b00);
        check("s4_fc0", frame_count0, 8'd2);
        wq.delete();

        // sink back-pressure mid-frame
        exp5 = '{18'h3F201, 18'h3F202, 18'h3F203, 18'h3F204, 18'h00205};
        for (int i = 0; i < 5; i++) q0.push_back(exp5[i]);
        cyc(3);
        full = 1'b1;
        cyc(1);
        check("s5_rd_en0", rd_en0, 1'b0);
        check("s5_wr_en", wr_en, 1'b0);
        cyc(4);
        check("s5_nowrite", wq.size(), 1);
        check("s5_grant_held", grant, 2'b01);
        full = 1'b0;
        cyc(10);
        check("s5_nwords", wq.size(), 5);
        for (int i = 0; i < 5; i++) check("s5_word", wq_at(i), exp5[i]);
        check("s5_abort", abort_count, 8'd1);
        check("s5_fc0", frame_count0, 8'd3);
        check("s5_din_hold", din, 18'h00205);
        wq.delete();

        // asynchronous reset mid-frame
        q0.push_back(18'h3F301); q0.push_back(18'h3F302);
        q0.push_back(18'h3F303); q0.push_back(18'h00304);
        cyc(3);
        sys_rst = 1'b1;
        #1;
        check("s6_grant", grant, 2'b00);
        check("s6_wr_en", wr_en, 1'b0);
        check("s6_din", din, 18'h0);
        check("s6_rd_en0", rd_en0, 1'b0);
        check("s6_counts", {frame_count0, frame_count1, drop_count, abort_count}, 32'h0);
        q0.delete();
        q1.delete();
        cyc(2);
        wq.delete();
        sys_rst = 1'b0;
        cyc(1);
        q0.push_back(18'h3F401); q0.push_back(18'h00402);
        cyc(8);
        check("s6_nwords", wq.size(), 2);
        check("s6_w0", wq_at(0), 18'h3F401);
        check("s6_w1", wq_at(1), 18'h00402);
        check("s6_fc", {frame_count0, frame_count1}, 16'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo18_rr_arb.md
FIFO18_RR_ARB -- requirements
Module: fifo18_rr_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter Timeout, default 8'd64: empty-cycle limit inside a granted frame before the frame is aborted.
Ports:
REQ-002 The block SHALL have sys_clk, input, 1 bit: single clock for all logic.
REQ-003 The block SHALL have sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have dout0 / dout1, input, 18 bits each: head word of source FIFO 0/1, first-word-fall-through; [17:16] is the tag (11 = timestamp word or both data bytes valid, 10 = high byte only, 00 = gap/terminator).
REQ-005 The block SHALL have empty0 / empty1, input, 1 bit each: source FIFO empty; doutN is valid while emptyN=0.
REQ-006 The block SHALL have rd_en0 / rd_en1, output, 1 bit each, combinational: pop the source head.
REQ-007 The block SHALL have din, output, 18 bits, registered: word written to the shared sink FIFO.
REQ-008 The block SHALL have wr_en, output, 1 bit, registered: sink write strobe.
REQ-009 The block SHALL have full, input, 1 bit: sink programmable-full, asserted with at least 1 free entry of slack.
REQ-010 The block SHALL have frame_count0 / frame_count1, output, 8 bits each: frames forwarded per port, wrapping.
REQ-011 The block SHALL have drop_count, output, 8 bits: stray 00-tag words discarded while idle, wrapping.
REQ-012 The block SHALL have abort_count, output, 8 bits: timeout aborts, wrapping.
REQ-013 The block SHALL have grant, output, 2 bits: one-hot current owner; 00 means idle.

Function
REQ-014 The FSM SHALL have states IDLE, GNT0 and GNT1, plus 1-bit last_port (the port most recently granted).
REQ-015 In IDLE, a port SHALL be eligible when emptyN=0 and doutN[17]=1.
- One eligible port: go to GNTN.
- Both eligible: grant the port not equal to last_port.
REQ-016 In IDLE, a port whose non-empty head has doutN[17]=0 SHALL be popped and discarded, with drop_count+1.
- At most one pop per cycle.
- Eligibility beats discard.
- Between two discard candidates, the port not equal to last_port wins.
REQ-017 In GNTN, rd_enN SHALL equal (emptyN=0 && full=0); the other rd_en SHALL be 0.
REQ-018 Each pop in GNTN SHALL produce din=doutN and wr_en=1 on the next cycle (one-cycle latency); at most one word per cycle.
REQ-019 In GNTN, a popped word with doutN[17:16]=00 SHALL be the frame terminator:
- the word is forwarded;
- frame_countN increments;
- last_port becomes N;
- the state returns to IDLE on the next cycle.
REQ-020 The frame SHALL be atomic: no word from the other port is written between the grant and the terminator.
REQ-021 Idle counter idle_cnt:
- cleared on grant and on each pop;
- increments in GNTN while emptyN=1 and full=0;
- holds while full=1.
REQ-022 When idle_cnt reaches Timeout and full=0, the block SHALL write din=18'h00000 with wr_en=1, increment abort_count, set last_port=N and enter IDLE. No source pop occurs that cycle.
REQ-023 When wr_en=0, din SHALL hold its previous value.
REQ-024 While full=1, no pop and no write SHALL occur, and the state SHALL be held.
REQ-025 All counters SHALL wrap from 8'hFF to 8'h00 without saturation.
REQ-026 The grant output SHALL be 01 in GNT0, 10 in GNT1 and 00 in IDLE.
REQ-027 The implementation SHALL be 120-400 lines of RTL, with a single always block for the FSM plus combinational rd_en.

Reset
REQ-028 While sys_rst=1, regardless of sys_clk:
- state=IDLE, last_port=1 (port 0 wins the first tie);
- din=18'h00000, wr_en=0, grant=00, idle_cnt=0;
- all counters 0.
REQ-029 rd_en0 and rd_en1 SHALL be 0 during reset.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame: no terminator is written, and no counter retains its value.
REQ-031 After reset release, the first grant SHALL occur no earlier than the first rising sys_clk edge with sys_rst=0.

Verification
REQ-032 Scenario: port0 holds {3FFAA,3FFBB,2CC00,00000}, port1 empty, full=0 -> grant=01, wr_en high for exactly 4 consecutive cycles starting 2 cycles after empty0 falls, din sequence identical, frame_count0=1, grant=00 afterwards.
REQ-033 Scenario: both ports hold one 3-word frame with terminator, presented in the same cycle after reset -> port0 frame fully written, then port1 frame, with no interleaving; frame_count0=frame_count1=1; a second simultaneous pair also goes port0 first, since port1 was served last.
REQ-034 Scenario: port0 head 00000 x3, idle -> three discard pops, wr_en never high, drop_count=3.
REQ-035 Scenario: port0 frame stalls (empty0=1) after 2 words, Timeout=4 -> exactly 4 idle cycles, then din=00000 with wr_en=1, abort_count=1, grant=00.
REQ-036 Scenario: full=1 for 5 cycles mid-frame -> rd_en0=0, no writes, idle_cnt not advancing, no abort; on release, transfer resumes with no word lost or duplicated.
REQ-037 Scenario: sys_rst pulsed asynchronously mid-frame -> all outputs at reset values before the next clock edge; the next frame transfers cleanly.
